// File: rtl/conv_accum.sv
// Reduces the nine signed products of one 3x3 window through a pipelined adder tree,
// accumulates NUM_CH channel beats per pixel, then applies optional ReLU and saturation.
module conv_accum #(
  parameter int unsigned width     = 4,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RELU      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [9*2*width-1:0]     prod_i,
  input  logic                     prod_valid_i,
  input  logic                     clr_i,
  output logic [OUT_WIDTH-1:0]     out_data_o,
  output logic                     out_valid_o,
  output logic                     partial_o
);

  localparam int unsigned ANS_WIDTH = 2 * width;
  localparam int unsigned TREE_W    = ANS_WIDTH + 4;
  localparam int unsigned ACC_W     = TREE_W + $clog2(NUM_CH) + 1;
  localparam int unsigned CNT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic signed [ANS_WIDTH-1:0] p_t;
  typedef logic signed [ANS_WIDTH:0]   s1_t;
  typedef logic signed [ANS_WIDTH+1:0] s2_t;
  typedef logic signed [ANS_WIDTH+2:0] s3_t;
  typedef logic signed [TREE_W-1:0]    s4_t;
  typedef logic signed [ACC_W-1:0]     acc_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;
  typedef logic [CNT_W-1:0]            cnt_t;

  localparam acc_t SatMax = acc_t'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam acc_t SatMin = acc_t'(-(longint'(1) << (OUT_WIDTH - 1)));
  localparam cnt_t CntLast = cnt_t'(NUM_CH - 1);

  p_t   p [9];
  s1_t  a_d [5];
  s1_t  a_q [5];
  s2_t  b_d [3];
  s2_t  b_q [3];
  s3_t  c_d [2];
  s3_t  c_q [2];
  s4_t  sum_d, sum_q;
  logic v1_q, v2_q, v3_q, v4_q;

  acc_t acc_d, acc_q;
  cnt_t cnt_d, cnt_q;
  out_t out_data_d, out_data_q;
  logic out_valid_d, out_valid_q;
  logic partial_d, partial_q;
  acc_t total, relu_v;

  // Every add is sign-extended one bit wider than its operands, so the tree never overflows.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      p[k] = p_t'(prod_i[k*ANS_WIDTH +: ANS_WIDTH]);
    end
    a_d[0] = s1_t'(p[0]) + s1_t'(p[1]);
    a_d[1] = s1_t'(p[2]) + s1_t'(p[3]);
    a_d[2] = s1_t'(p[4]) + s1_t'(p[5]);
    a_d[3] = s1_t'(p[6]) + s1_t'(p[7]);
    a_d[4] = s1_t'(p[8]);
    b_d[0] = s2_t'(a_q[0]) + s2_t'(a_q[1]);
    b_d[1] = s2_t'(a_q[2]) + s2_t'(a_q[3]);
    b_d[2] = s2_t'(a_q[4]);
    c_d[0] = s3_t'(b_q[0]) + s3_t'(b_q[1]);
    c_d[1] = s3_t'(b_q[2]);
    sum_d  = s4_t'(c_q[0]) + s4_t'(c_q[1]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      sum_q <= '0;
      for (int k = 0; k < 5; k++) a_q[k] <= '0;
      for (int k = 0; k < 3; k++) b_q[k] <= '0;
      for (int k = 0; k < 2; k++) c_q[k] <= '0;
    end else begin
      v1_q <= prod_valid_i & ~clr_i;
      v2_q <= v1_q & ~clr_i;
      v3_q <= v2_q & ~clr_i;
      v4_q <= v3_q & ~clr_i;
      if (prod_valid_i) a_q <= a_d;
      if (v1_q) b_q <= b_d;
      if (v2_q) c_q <= c_d;
      if (v3_q) sum_q <= sum_d;
    end
  end

  always_comb begin
    total       = ((cnt_q == '0) ? acc_t'(0) : acc_q) + acc_t'(sum_q);
    relu_v      = ((RELU != 0) && (total < 0)) ? acc_t'(0) : total;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    // clr takes priority over a beat completing in the same cycle.
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (v4_q) begin
      if (cnt_q == CntLast) begin
        if (relu_v > SatMax) begin
          out_data_d = out_t'(SatMax);
        end else if (relu_v < SatMin) begin
          out_data_d = out_t'(SatMin);
        end else begin
          out_data_d = out_t'(relu_v);
        end
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
    partial_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      partial_q   <= partial_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign partial_o   = partial_q;

endmodule
